// File: rtl/secure_link_pkg.sv
// -----------------------------------------------------------------------------
// secure_link_pkg
// Shared definitions for the serial Hamming(7,4) link (transmit and receive).
//   CODE_W / DATA_W : codeword and data widths
//   SYN_W           : syndrome width
//   POS_*           : 1-based bit positions of each field within a frame
//   rx_state_e      : receive FSM state encoding
// -----------------------------------------------------------------------------
package secure_link_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Serial frame order: p1, p2, D0, p4, D1, D2, D3
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_D0 = 3;
  localparam int POS_P4 = 4;
  localparam int POS_D1 = 5;
  localparam int POS_D2 = 6;
  localparam int POS_D3 = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DECODE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/hamming74_decoder.sv
// -----------------------------------------------------------------------------
// hamming74_decoder
// Purely combinational Hamming(7,4) single-error-correcting decoder.
//   code     [6:0] in  : received codeword, code[k-1] holds frame position k
//   data     [3:0] out : corrected data {D3,D2,D1,D0}
//   syndrome [2:0] out : {s4,s2,s1}, the erroneous position (1..7), 0 = clean
// -----------------------------------------------------------------------------
module hamming74_decoder
  import secure_link_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic [SYN_W-1:0]  syndrome
);

  logic [CODE_W-1:0] fixed;

  assign syndrome[0] = code[POS_P1-1] ^ code[POS_D0-1] ^ code[POS_D1-1] ^ code[POS_D3-1];
  assign syndrome[1] = code[POS_P2-1] ^ code[POS_D0-1] ^ code[POS_D2-1] ^ code[POS_D3-1];
  assign syndrome[2] = code[POS_P4-1] ^ code[POS_D1-1] ^ code[POS_D2-1] ^ code[POS_D3-1];

  always_comb begin
    fixed = code;
    // The syndrome is the 1-based position of the flipped bit.
    if (syndrome != '0) begin
      fixed[syndrome - 3'd1] = ~code[syndrome - 3'd1];
    end
    data = {fixed[POS_D3-1], fixed[POS_D2-1], fixed[POS_D1-1], fixed[POS_D0-1]};
  end

endmodule

// File: rtl/secure_receiver.sv
// -----------------------------------------------------------------------------
// secure_receiver
// Receives one strobe-qualified serial Hamming(7,4) codeword from one of NUM_CH
// lines, corrects any single-bit error and presents the data with a one-cycle
// valid pulse.
//   clk, rst (async, active-high)
//   strobe, sof     : bit qualifier / start-of-frame (bit position 1)
//   d_in[NUM_CH]    : serial lines; ch_sel picks one, captured with sof
//   d_out[3:0]      : corrected data, held until the next valid
//   valid           : one-cycle pulse when d_out/syndrome/err_corrected update
//   err_corrected   : delivered frame had a nonzero syndrome
//   syndrome[2:0]   : erroneous position, 0 = clean
//   err_count       : saturating corrected-error counter, only present when
//                     SECURE_RX_ERRCNT_EN is defined
// -----------------------------------------------------------------------------
module secure_receiver
  import secure_link_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      strobe,
  input  logic                      sof,
  input  logic [NUM_CH-1:0]         d_in,
  input  logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic [DATA_W-1:0]         d_out,
  output logic                      valid,
  output logic                      err_corrected,
  output logic [SYN_W-1:0]          syndrome
`ifdef SECURE_RX_ERRCNT_EN
  ,
  output logic [CNT_W-1:0]          err_count
`endif
);

  localparam int CH_W = $clog2(NUM_CH);

  rx_state_e           state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [CODE_W-1:0]   sr_q, sr_d;
  logic [CH_W-1:0]     ch_q, ch_d;

  // Decode result is registered once in DECODE and delivered one edge later,
  // so valid appears on the second edge after the c7 sample.
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   pend_data_q, pend_data_d;
  logic [SYN_W-1:0]    pend_syn_q, pend_syn_d;

  logic [DATA_W-1:0]   d_out_q, d_out_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [SYN_W-1:0]    syn_q, syn_d;

  logic [DATA_W-1:0]   dec_data;
  logic [SYN_W-1:0]    dec_syn;

  hamming74_decoder u_dec (
    .code     (sr_q),
    .data     (dec_data),
    .syndrome (dec_syn)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    ch_d        = ch_q;
    pend_d      = 1'b0;
    pend_data_d = pend_data_q;
    pend_syn_d  = pend_syn_q;

    // sof is accepted in every state; in SHIFT it silently drops the partial
    // frame, in DECODE it starts the next frame back-to-back.
    if (strobe && sof) begin
      ch_d    = ch_sel;
      sr_d    = '0;
      sr_d[0] = d_in[ch_sel];
      cnt_d   = 3'd1;
      state_d = SHIFT;
    end else if (state_q == SHIFT && strobe) begin
      sr_d[cnt_q] = d_in[ch_q];
      cnt_d       = cnt_q + 3'd1;
      if (cnt_q == 3'd6) begin
        state_d = DECODE;
      end
    end else if (state_q == DECODE) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end

    if (state_q == DECODE) begin
      pend_d      = 1'b1;
      pend_data_d = dec_data;
      pend_syn_d  = dec_syn;
    end

    valid_d = pend_q;
    d_out_d = d_out_q;
    syn_d   = syn_q;
    err_d   = err_q;
    if (pend_q) begin
      d_out_d = pend_data_q;
      syn_d   = pend_syn_q;
      err_d   = (pend_syn_q != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      ch_q        <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_syn_q  <= '0;
      d_out_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      syn_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      ch_q        <= ch_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_syn_q  <= pend_syn_d;
      d_out_q     <= d_out_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      syn_q       <= syn_d;
    end
  end

  assign d_out         = d_out_q;
  assign valid         = valid_q;
  assign err_corrected = err_q;
  assign syndrome      = syn_q;

`ifdef SECURE_RX_ERRCNT_EN
  logic [CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    // Counts at delivery time and sticks at all-ones.
    if (pend_q && (pend_syn_q != '0) && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_secure_receiver.sv
// -----------------------------------------------------------------------------
// tb_secure_receiver
// Directed plus randomized frames against a nearest-codeword reference model.
// Build with SECURE_RX_ERRCNT_EN defined to also check err_count.
// -----------------------------------------------------------------------------
module tb_secure_receiver;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic        sof;
  logic [3:0]  d_in;
  logic [1:0]  ch_sel;
  logic [3:0]  d_out;
  logic        valid;
  logic        err_corrected;
  logic [2:0]  syndrome;
`ifdef SECURE_RX_ERRCNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  secure_receiver #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .strobe        (strobe),
    .sof           (sof),
    .d_in          (d_in),
    .ch_sel        (ch_sel),
    .d_out         (d_out),
    .valid         (valid),
    .err_corrected (err_corrected),
    .syndrome      (syndrome)
`ifdef SECURE_RX_ERRCNT_EN
    ,
    .err_count     (err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] d;
    logic [2:0] s;
    logic       e;
    int         ec;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   model_ec = 0;
  logic [3:0] last_d;
  logic [2:0] last_s;
  logic       last_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with the edge count at which it was seen.
  always @(posedge clk) begin
    #1;
    if (valid === 1'b1) begin
      res_t r;
      r.cyc = cyc;
      r.d   = d_out;
      r.s   = syndrome;
      r.e   = err_corrected;
`ifdef SECURE_RX_ERRCNT_EN
      r.ec  = int'(err_count);
`else
      r.ec  = 0;
`endif
      obs_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Reference: the Hamming(7,4) code is perfect, so every received word lies
  // within distance 1 of exactly one codeword; the differing bit is the error.
  task automatic ref_decode(input logic [6:0] rx, output logic [3:0] d, output logic [2:0] s);
    logic [6:0] diff;
    d = 4'd0;
    s = 3'd0;
    for (int k = 0; k < 16; k++) begin
      diff = rx ^ enc(4'(k));
      if ($countones(diff) <= 1) begin
        d = 4'(k);
        for (int b = 0; b < 7; b++) if (diff[b]) s = 3'(b + 1);
      end
    end
  endtask

  // Sends nbits of rx on channel ch; a full frame also queues its expectation.
  task automatic send_frame(input int ch, input logic [6:0] rx, input int nbits,
                            input int max_gap, input bit noise);
    res_t r;
    for (int i = 0; i < nbits; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        strobe = 1'b0;
        sof    = 1'b0;
        d_in   = noise ? 4'($urandom) : 4'd0;
        ch_sel = noise ? 2'($urandom) : 2'(ch);
        @(posedge clk); #1;
      end
      strobe     = 1'b1;
      sof        = (i == 0);
      d_in       = noise ? 4'($urandom) : 4'd0;
      d_in[ch]   = rx[i];
      ch_sel     = (i == 0 || !noise) ? 2'(ch) : 2'($urandom);
      @(posedge clk); #1;
    end
    strobe = 1'b0;
    sof    = 1'b0;
    if (nbits == 7) begin
      ref_decode(rx, r.d, r.s);
      r.e   = (r.s != 3'd0);
      r.cyc = cyc + 2;
`ifdef SECURE_RX_ERRCNT_EN
      if (r.e && model_ec < (1 << CNT_W) - 1) model_ec++;
`endif
      r.ec  = model_ec;
      exp_q.push_back(r);
    end
  endtask

  task automatic drain_and_compare(input string tag);
    int n;
    repeat (6) @(posedge clk);
    #1;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      $display("txn %s[%0d]: cyc=%0d d_out=%b syn=%0d err=%0b (exp cyc=%0d d=%b syn=%0d)",
               tag, i, obs_q[i].cyc, obs_q[i].d, obs_q[i].s, obs_q[i].e,
               exp_q[i].cyc, exp_q[i].d, exp_q[i].s);
      chk({tag, "_latency"}, obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, "_d_out"},   obs_q[i].d,   exp_q[i].d);
      chk({tag, "_syndrome"}, obs_q[i].s,  exp_q[i].s);
      chk({tag, "_err_corr"}, obs_q[i].e,  exp_q[i].e);
      chk({tag, "_err_count"}, obs_q[i].ec, exp_q[i].ec);
    end
    if (exp_q.size() > 0) begin
      last_d = exp_q[exp_q.size()-1].d;
      last_s = exp_q[exp_q.size()-1].s;
      last_e = exp_q[exp_q.size()-1].e;
      chk({tag, "_hold_d_out"}, d_out, last_d);
      chk({tag, "_hold_syn"},   syndrome, last_s);
      chk({tag, "_hold_err"},   err_corrected, last_e);
      chk({tag, "_valid_low"},  valid, 1'b0);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] cw;
    rst    = 1'b1;
    strobe = 1'b0;
    sof    = 1'b0;
    d_in   = 4'd0;
    ch_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_d_out", d_out, 4'd0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_err",   err_corrected, 1'b0);
    chk("reset_syn",   syndrome, 3'd0);
`ifdef SECURE_RX_ERRCNT_EN
    chk("reset_err_count", err_count, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean frame, D=1011 on channel 2
    cw = enc(4'b1011);
    chk("enc_1011", cw, 7'b1010101);
    send_frame(2, cw, 7, 0, 1'b0);
    drain_and_compare("clean");

    // Data-bit error at position 5
    send_frame(2, cw ^ 7'b0010000, 7, 0, 1'b0);
    drain_and_compare("err_pos5");

    // Parity-bit error at position 1
    send_frame(2, cw ^ 7'b0000001, 7, 0, 1'b0);
    drain_and_compare("err_pos1");

    // Back-to-back: second sof lands in the DECODE cycle of the first
    send_frame(1, enc(4'b1011), 7, 0, 1'b0);
    send_frame(1, enc(4'b0000), 7, 0, 1'b0);
    drain_and_compare("b2b");

    // Abort after 4 bits, restart on another channel
    send_frame(0, enc(4'b0110), 4, 0, 1'b0);
    send_frame(3, enc(4'b1001) ^ 7'b1000000, 7, 0, 1'b0);
    drain_and_compare("abort");

    // Leave nonzero outputs, then async reset mid-frame
    send_frame(2, enc(4'b1111) ^ 7'b0000100, 7, 0, 1'b0);
    drain_and_compare("pre_rst");
    send_frame(2, enc(4'b0101), 3, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_d_out", d_out, 4'd0);
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_err",   err_corrected, 1'b0);
    chk("async_rst_syn",   syndrome, 3'd0);
`ifdef SECURE_RX_ERRCNT_EN
    chk("async_rst_err_count", err_count, 0);
`endif
    model_ec = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(0, enc(4'b0111), 7, 0, 1'b0);
    drain_and_compare("post_rst");

    // Random frames: gaps, noise on other lines, ch_sel toggling, 0-2 errors
    for (int f = 0; f < 30; f++) begin
      logic [6:0] rx;
      int kind;
      int p1, p2;
      rx   = enc(4'($urandom));
      kind = int'($urandom_range(0, 2));
      p1   = int'($urandom_range(0, 6));
      p2   = (p1 + 1 + int'($urandom_range(0, 5))) % 7;
      if (kind >= 1) rx[p1] = ~rx[p1];
      if (kind == 2) rx[p2] = ~rx[p2];
      send_frame(int'($urandom_range(0, NUM_CH - 1)), rx, 7,
                 ($urandom_range(0, 1) == 0) ? 0 : 3, 1'b1);
    end
    drain_and_compare("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secure_receiver.md
Name: secure_receiver

Overview:
- Receive-side counterpart of the team's serial Hamming(7,4) router.
- Captures one strobe-qualified serial codeword from one of NUM_CH output lines and corrects any single-bit error.
- Presents the 4-bit data word with a one-cycle valid pulse and the error syndrome.
- Sits at the far end of each router output bundle, feeding the downstream consumer.

Parameters:
- NUM_CH, 4, number of serial input lines (one per router destination).
- CNT_W, 8, width of the corrected-error counter (used only when the optional feature is enabled).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset. Asynchronous and active-high; one clock domain only.
- strobe  input  1  bit-valid qualifier; the line is sampled on a rising clk only when strobe=1.
- sof  input  1  start-of-frame; meaningful only with strobe=1, marks bit position 1.
- d_in  input  NUM_CH  serial lines, one per channel.
- ch_sel  input  $clog2(NUM_CH)  channel to listen to; captured when sof is accepted.
- d_out  output  4  corrected data {D3,D2,D1,D0}.
- valid  output  1  one-cycle pulse, d_out/syndrome/err_corrected updated.
- err_corrected  output  1  syndrome nonzero for the delivered frame (bit flipped).
- syndrome  output  3  {s4,s2,s1} = erroneous bit position (1..7), 0 = clean.
- err_count  output  CNT_W  present only with SECURE_RX_ERRCNT_EN.

Behaviour:
- Frame order, positions 1..7: p1, p2, D0, p4, D1, D2, D3.
- Encoder parity equations: p1=D0^D1^D3, p2=D0^D2^D3, p4=D1^D2^D3.
- Reset (async, any time): state=IDLE, bit counter=0, shift register=0, latched channel=0, and every output (d_out, valid, err_corrected, syndrome, err_count) forced to 0. A partial frame is discarded and never reported.
- FSM states are IDLE, SHIFT and DECODE:
  - IDLE: strobe&sof latches ch_sel, stores d_in[ch_sel] as c1, count=1, and moves to SHIFT. Strobe without sof is ignored.
  - SHIFT: each strobe stores d_in[latched ch] at position count+1 and increments count. On storing c7, move to DECODE. Cycles with strobe=0 hold state (gaps allowed, no timeout).
  - sof in SHIFT: abort the current frame with no valid pulse, then restart as bit 1 with a fresh ch_sel.
  - DECODE (exactly one cycle): compute s1=c1^c3^c5^c7, s2=c2^c3^c6^c7, s4=c4^c5^c6^c7, and flip the bit at position S if S≠0. Register d_out={c7,c6,c5,c3} (corrected), syndrome=S, err_corrected=(S≠0), valid=1. Next state is IDLE.
  - strobe&sof in the DECODE cycle: accepted as bit 1 of the next frame (back-to-back supported), next state SHIFT with count=1. Strobe without sof in DECODE is ignored.
- Latency: valid rises on the second rising edge after the edge that sampled c7, and is high for exactly one cycle.
- d_out, syndrome and err_corrected hold their values until the next valid.
- Double-bit errors are miscorrected silently; this is inherent to Hamming(7,4) and is not flagged.
- ch_sel changes mid-frame have no effect.

Optional Feature:
- Macro: SECURE_RX_ERRCNT_EN.
- Defined: err_count increments on each valid with err_corrected=1, saturates at 2^CNT_W−1, and is cleared only by rst.
- Undefined: the err_count port and counter logic are absent.

Decomposition:
- Package secure_link_pkg holds:
  - CODE_W=7 and DATA_W=4.
  - Bit-position constants POS_P1=1, POS_P2=2, POS_D0=3, POS_P4=4, POS_D1=5, POS_D2=6, POS_D3=7.
  - FSM state enum.
- The same package is shared with the transmit side.
- One combinational sub-module, hamming74_decoder, maps a 7-bit codeword to {data[3:0], syndrome[2:0]}; the FSM instantiates it in DECODE.

Test Plan:
- Clean frame, ch_sel=2, D=4'b1011: send 1,0,1,0,1,0,1 on d_in[2] → valid two edges after bit 7, d_out=4'b1011, syndrome=0, err_corrected=0.
- Same frame with bit 5 flipped (1,0,1,0,0,0,1) → d_out=4'b1011, syndrome=3'd5, err_corrected=1 (err_count=1 if SECURE_RX_ERRCNT_EN).
- Parity-bit error: flip pos 1 (0,0,1,0,1,0,1) → d_out=4'b1011, syndrome=1; data path untouched.
- Back-to-back: frame 1011 immediately followed by strobe&sof in the DECODE cycle carrying D=4'b0000 (all zeros) → two valid pulses, d_out 1011 then 0000, no bit lost.
- Abort/reset: assert sof after 4 bits → no valid for the first frame, the restarted frame decodes correctly; assert rst after 3 bits → all outputs 0 immediately (async), and the next full frame decodes normally.
- Gaps and channel isolation: random strobe=0 gaps and toggling ch_sel mid-frame with noise on the other lines → result identical to gap-free reception on the latched channel.
